store_buffer_dmem: RTL

//  Downstream data-memory stage of the single-cycle core: takes MemWrite/ALUResult/WriteData, returns ReadData.

---
 rtl/store_buffer_dmem_pkg.sv | 9 +
 rtl/sb_match_prio.sv | 38 +++
 rtl/store_buffer_dmem.sv | 95 +++++++++
 3 files changed

// File: rtl/store_buffer_dmem_pkg.sv
// store_buffer_dmem_pkg: shared widths and entry layout for the data-memory store buffer.
package store_buffer_dmem_pkg;
    localparam int XLEN = 32;
    localparam int WORD_LSB = 2;
    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
    } sb_entry_t;
endpackage

// File: rtl/sb_match_prio.sv
// sb_match_prio: DEPTH-way word-address compare; with STORE_FWD_EN also returns the youngest hit's data.
module sb_match_prio #(
    parameter int DEPTH = 4,
    parameter int WW = 30
`ifdef STORE_FWD_EN
    , parameter int DW = 32
`endif
) (
    input  logic [WW-1:0]            wa_i,
    input  logic [DEPTH-1:0]         vld_i,
    input  logic [DEPTH-1:0][WW-1:0] ent_wa_i,
`ifdef STORE_FWD_EN
    input  logic [DEPTH-1:0][DW-1:0] ent_data_i,
    input  logic [$clog2(DEPTH)-1:0] tail_i,
    output logic [DW-1:0]            hit_data_o,
`endif
    output logic                     any_hit_o
);
    logic [DEPTH-1:0] hit;
    always_comb begin
        hit = '0;
        for (int i = 0; i < DEPTH; i++) hit[i] = vld_i[i] && ent_wa_i[i] == wa_i;
    end
    assign any_hit_o = |hit;
`ifdef STORE_FWD_EN
    localparam int PW = $clog2(DEPTH);
    logic [PW-1:0] idx;
    // Walk oldest to youngest (tail-DEPTH .. tail-1) so the youngest hit wins.
    always_comb begin
        hit_data_o = '0;
        idx = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            idx = tail_i - PW'(k);
            if (hit[idx]) hit_data_o = ent_data_i[idx];
        end
    end
`endif
endmodule

// File: rtl/store_buffer_dmem.sv
// store_buffer_dmem: DEPTH-entry store FIFO draining to a valid/ready write port; loads read memory.
// STORE_FWD_EN: forward youngest matching buffered store to ReadData instead of stalling on a hit.
module store_buffer_dmem
    import store_buffer_dmem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW = XLEN,
    parameter int DW = XLEN
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MemWrite,
    input  logic [AW-1:0] ALUResult,
    input  logic [DW-1:0] WriteData,
    output logic [DW-1:0] ReadData,
    output logic          Stall,
    output logic [AW-1:0] mem_raddr,
    input  logic [DW-1:0] mem_rdata,
    output logic          bus_wvalid,
    input  logic          bus_wready,
    output logic [AW-1:0] bus_waddr,
    output logic [DW-1:0] bus_wdata
);
    localparam int PW = $clog2(DEPTH);
    localparam int WW = AW - WORD_LSB;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [PW:0] cnt_q, cnt_d;
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [DEPTH-1:0][AW-1:0] addr_q;
    logic [DEPTH-1:0][DW-1:0] data_q;
    logic [DEPTH-1:0][WW-1:0] ent_wa;
    logic push, pop, full, any_hit;
    assign full = cnt_q == (PW+1)'(DEPTH);
    assign bus_wvalid = cnt_q != '0;
    assign pop = bus_wvalid && bus_wready;
    // Full check uses the pre-pop count: no same-cycle dequeue bypass.
    assign push = MemWrite && !full;
    assign bus_waddr = addr_q[head_q];
    assign bus_wdata = data_q[head_q];
    assign mem_raddr = ALUResult;
    always_comb begin
        ent_wa = '0;
        for (int i = 0; i < DEPTH; i++) ent_wa[i] = addr_q[i][AW-1:WORD_LSB];
    end
`ifdef STORE_FWD_EN
    logic [DW-1:0] hit_data;
    sb_match_prio #(.DEPTH(DEPTH), .WW(WW), .DW(DW)) u_match (
        .wa_i(ALUResult[AW-1:WORD_LSB]),
        .vld_i(vld_q),
        .ent_wa_i(ent_wa),
        .ent_data_i(data_q),
        .tail_i(tail_q),
        .hit_data_o(hit_data),
        .any_hit_o(any_hit)
    );
    assign ReadData = any_hit ? hit_data : mem_rdata;
    assign Stall = MemWrite && full;
`else
    sb_match_prio #(.DEPTH(DEPTH), .WW(WW)) u_match (
        .wa_i(ALUResult[AW-1:WORD_LSB]),
        .vld_i(vld_q),
        .ent_wa_i(ent_wa),
        .any_hit_o(any_hit)
    );
    assign ReadData = mem_rdata;
    assign Stall = MemWrite ? full : any_hit;
`endif
    always_comb begin
        head_d = head_q + PW'(pop);
        tail_d = tail_q + PW'(push);
        cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
        vld_d = vld_q;
        if (pop) vld_d[head_q] = 1'b0;
        if (push) vld_d[tail_q] = 1'b1;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q <= '0;
            vld_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q <= cnt_d;
            vld_q <= vld_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            addr_q[tail_q] <= ALUResult;
            data_q[tail_q] <= WriteData;
        end
    end
endmodule
